// File: rtl/rel_ops_pkg.sv
// rtl/rel_ops_pkg.sv - shared flag struct and reset value for the relational comparator
package rel_ops_pkg;

  typedef struct packed {
    logic eq;
    logic neq;
    logic gt;
    logic lt;
    logic gte;
    logic lte;
  } rel_flags_t;

  localparam rel_flags_t REL_FLAGS_RESET = '0;

endpackage

// File: rtl/rel_cmp_core.sv
// rtl/rel_cmp_core.sv - combinational compare: one eq term, one lt term, rest derived
module rel_cmp_core
  import rel_ops_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output rel_flags_t       flags
);

  logic w_eq;
  logic w_lt;

  assign w_eq = (A == B);

  // Signedness only changes how the MSB is weighted in the less-than term.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_lt = ($signed(A) < $signed(B));
    end else begin : g_unsigned
      assign w_lt = (A < B);
    end
  endgenerate

  always_comb begin
    flags     = REL_FLAGS_RESET;
    flags.eq  = w_eq;
    flags.lt  = w_lt;
    flags.gt  = ~w_eq & ~w_lt;
    flags.neq = ~w_eq;
    flags.gte = ~w_lt;
    flags.lte = w_lt | w_eq;
  end

endmodule

// File: rtl/relational_operators.sv
// rtl/relational_operators.sv - registered six-flag comparator, one-cycle latency
module relational_operators
  import rel_ops_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             eq,
  output logic             neq,
  output logic             gt,
  output logic             lt,
  output logic             gte,
  output logic             lte,
  output logic             out_valid
);

  rel_flags_t w_flags;
  rel_flags_t r_flags;
  logic       r_out_valid;

  rel_cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .A     (A),
    .B     (B),
    .flags (w_flags)
  );

  // Flags hold across idle cycles; only out_valid tracks in_valid each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags     <= REL_FLAGS_RESET;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_flags <= w_flags;
      end
    end
  end

  assign eq        = r_flags.eq;
  assign neq       = r_flags.neq;
  assign gt        = r_flags.gt;
  assign lt        = r_flags.lt;
  assign gte       = r_flags.gte;
  assign lte       = r_flags.lte;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_relational_operators.sv
// tb/tb_relational_operators.sv - scoreboard bench, unsigned and signed instances
module tb_relational_operators;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;

  logic eq_u, neq_u, gt_u, lt_u, gte_u, lte_u, ov_u;
  logic eq_s, neq_s, gt_s, lt_s, gte_s, lte_s, ov_s;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [6:0] u;
    logic [6:0] s;
  } exp_t;

  exp_t exp_q[$];

  logic [5:0] m_u = '0;
  logic [5:0] m_s = '0;

  always #5 clk = ~clk;

  relational_operators #(.WIDTH(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .eq(eq_u), .neq(neq_u), .gt(gt_u), .lt(lt_u), .gte(gte_u), .lte(lte_u),
    .out_valid(ov_u)
  );

  relational_operators #(.WIDTH(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .eq(eq_s), .neq(neq_s), .gt(gt_s), .lt(lt_s), .gte(gte_s), .lte(lte_s),
    .out_valid(ov_s)
  );

  // Reference: map operands to integers, then use ordinary integer comparisons.
  function automatic logic [5:0] ref_cmp(input logic [3:0] a, input logic [3:0] b, input bit sgn);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    if (sgn && av >= 8) av = av - 16;
    if (sgn && bv >= 8) bv = bv - 16;
    return {av == bv, av != bv, av > bv, av < bv, av >= bv, av <= bv};
  endfunction

  task automatic apply(input bit r, input bit v, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic ov;
    @(posedge clk);
    #2;
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    if (r) begin
      m_u = '0;
      m_s = '0;
      ov  = 1'b0;
    end else if (v) begin
      m_u = ref_cmp(a, b, 1'b0);
      m_s = ref_cmp(a, b, 1'b1);
      ov  = 1'b1;
    end else begin
      ov  = 1'b0;
    end
    e.u = {ov, m_u};
    e.s = {ov, m_s};
    exp_q.push_back(e);
  endtask

  task automatic check_one(input string name, input logic [6:0] got, input logic [6:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got {ov,eq,neq,gt,lt,gte,lte}=%b want=%b at %0t", name, got, want, $time);
    end
    if (got[6] === 1'b1) begin
      compared++;
      if ($countones(got[3:2]) + int'(got[5]) != 1 || got[4] !== ~got[5] ||
          got[1] !== (got[3] | got[5]) || got[0] !== (got[2] | got[5])) begin
        mismatched++;
        $display("FAIL %s_invariant: got=%b want one-hot lt/eq/gt with consistent derived flags", name, got);
      end
    end
  endtask

  // Monitor: each expectation queued before an edge is checked at the following negedge.
  initial begin
    int n;
    exp_t e;
    forever begin
      @(posedge clk);
      n = exp_q.size();
      @(negedge clk);
      if (n > 0) begin
        e = exp_q.pop_front();
        check_one("unsigned", {ov_u, eq_u, neq_u, gt_u, lt_u, gte_u, lte_u}, e.u);
        check_one("signed",   {ov_s, eq_s, neq_s, gt_s, lt_s, gte_s, lte_s}, e.s);
      end
    end
  end

  initial begin
    apply(1, 0, 4'd0, 4'd0);
    apply(1, 0, 4'd0, 4'd0);
    apply(0, 1, 4'd5, 4'd5);
    apply(0, 1, 4'd3, 4'd7);
    apply(0, 1, 4'd9, 4'd2);
    apply(0, 0, 4'd0, 4'd15);
    apply(0, 0, 4'd0, 4'd15);
    apply(0, 1, 4'd4, 4'd6);
    apply(0, 1, 4'd8, 4'd8);
    apply(0, 1, 4'd1, 4'd0);
    apply(1, 1, 4'd4, 4'd6);
    apply(0, 1, 4'd4, 4'd6);
    apply(0, 1, 4'hF, 4'h1);
    apply(0, 1, 4'd0, 4'd0);
    apply(0, 1, 4'd15, 4'd15);
    apply(0, 1, 4'd15, 4'd0);
    apply(0, 1, 4'h8, 4'h7);
    apply(0, 1, 4'h7, 4'h8);
    apply(0, 1, 4'hF, 4'h0);
    apply(0, 1, 4'h8, 4'h8);
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    apply(0, 0, 4'd0, 4'd0);
    apply(0, 0, 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
